// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA bus sequencer between the 6502 core and the shared memory/IO bus.
// Passes CPU cycles through while idle. A CPU write to DMA_REG_ADDR halts the CPU and
// copies one page ({page,00}..{page,XFER_LEN-1}) to OAM_DATA_ADDR, one read+write per byte.
// Optional: define OAM_DMA_PARITY_ALIGN_EN to insert an ALIGN cycle when the halt lands on an odd cycle.
// Ports:
//   clk, reset_n       clock (posedge) and asynchronous active-low reset
//   cpu_ab/do/we       CPU address, write data, write enable
//   cpu_rdy            CPU RDY, low while the DMA owns the bus
//   bus_ab/do/we       address, write data, write enable to memory/IO
//   bus_di             combinational read data from memory/IO
//   dma_busy           high while the DMA owns the bus
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] bus_ab,
    output logic [7:0]  bus_do,
    output logic        bus_we,
    input  logic [7:0]  bus_di,
    output logic        dma_busy
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state, state_nxt;
    logic [7:0] page, idx, data;
    logic       trig;

    assign trig     = (state == IDLE) && cpu_we && (cpu_ab == DMA_REG_ADDR);
    assign cpu_rdy  = (state == IDLE);
    assign dma_busy = ~cpu_rdy;

`ifdef OAM_DMA_PARITY_ALIGN_EN
    // Free-running cycle parity; 1 on odd cycles since reset release.
    logic parity;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) parity <= 1'b0;
        else          parity <= ~parity;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        bus_ab    = cpu_ab;
        bus_do    = cpu_do;
        bus_we    = cpu_we;
        case (state)
            IDLE:  state_nxt = trig ? HALT : IDLE;
            // HALT/ALIGN: CPU address stays on the bus as a harmless dummy read.
            HALT: begin
                bus_we = 1'b0;
`ifdef OAM_DMA_PARITY_ALIGN_EN
                state_nxt = parity ? ALIGN : READ;
`else
                state_nxt = READ;
`endif
            end
            ALIGN: begin
                bus_we    = 1'b0;
                state_nxt = READ;
            end
            READ: begin
                bus_ab    = {page, idx};
                bus_we    = 1'b0;
                state_nxt = WRITE;
            end
            WRITE: begin
                bus_ab    = OAM_DATA_ADDR;
                bus_do    = data;
                bus_we    = 1'b1;
                state_nxt = (idx == LAST_IDX) ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            page <= 8'h00;
            idx  <= 8'h00;
            data <= 8'h00;
        end else begin
            if (trig) begin
                page <= cpu_do;
                idx  <= 8'h00;
            end
            if (state == READ)  data <= bus_di;
            // 8-bit wrap keeps the source inside the page.
            if (state == WRITE) idx <= idx + 8'd1;
        end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed self-checking bench for oam_dma_ctrl with a byte-wide memory model.
module tb_oam_dma_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] bus_ab;
    logic [7:0]  bus_do;
    logic        bus_we;
    logic [7:0]  bus_di;
    logic        dma_busy;

`ifdef OAM_DMA_PARITY_ALIGN_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic [7:0]  mem [65536];
    logic        tpar;
    logic [15:0] rq[$];
    logic [7:0]  wq[$];
    int          checks = 0;
    int          failures = 0;

    oam_dma_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
        .bus_ab(bus_ab), .bus_do(bus_do), .bus_we(bus_we), .bus_di(bus_di),
        .dma_busy(dma_busy)
    );

    assign bus_di = mem[bus_ab];

    always #5 clk = ~clk;

    // Expected cycle parity: 1 on odd cycles counted from reset release.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) tpar <= 1'b0;
        else          tpar <= ~tpar;

    // Record DMA source reads (anything but the dummy read of cpu_ab) and OAM writes.
    always @(posedge clk)
        if (reset_n && dma_busy) begin
            if (bus_we && bus_ab == 16'h2004) wq.push_back(bus_do);
            else if (!bus_we && bus_ab != cpu_ab) rq.push_back(bus_ab);
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one transfer from a negedge. pre: trigger already on the CPU pins.
    // hold: keep writing nxt to 0x4014 during the stall (must be ignored, then retriggers).
    task automatic dma_run(input logic [7:0] page, input bit pre, input bit hold, input logic [7:0] nxt);
        int n;
        int err;
        int exp_stall;
        logic [15:0] a;
        if (!pre) begin
            cpu_ab = 16'h4014;
            cpu_we = 1'b1;
            cpu_do = page;
        end
        rq.delete();
        wq.delete();
        #1 check("trig_pass", {bus_ab, bus_do, bus_we}, {16'h4014, page, 1'b1});
        @(posedge clk);
        @(negedge clk);
        exp_stall = (ALN && tpar) ? 514 : 513;
        if (hold) begin
            cpu_ab = 16'h4014;
            cpu_we = 1'b1;
            cpu_do = nxt;
        end else begin
            cpu_ab = 16'h8000;
            cpu_we = 1'b0;
            cpu_do = 8'hEE;
        end
        n = 0;
        while (!cpu_rdy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("stall", n, exp_stall);
        check("wr_cnt", wq.size(), 256);
        check("rd_cnt", rq.size(), 256);
        err = 0;
        for (int i = 0; i < 256; i++) begin
            a = {page, 8'(i)};
            if (i >= wq.size() || wq[i] !== mem[a]) err++;
            if (i >= rq.size() || rq[i] !== a) err++;
        end
        check("seq", err, 0);
        check("first_rd", rq[0], {page, 8'h00});
        check("last_rd", rq[255], {page, 8'hFF});
        check("last_wr", wq[255], mem[{page, 8'hFF}]);
    endtask

    // Arrange for the HALT cycle to have the requested parity.
    task automatic align_to(input bit odd);
        if ((~tpar) != odd) @(negedge clk);
    endtask

    logic [15:0] va [4] = '{16'h4015, 16'h4014, 16'h2004, 16'h4013};
    logic [7:0]  vd [4] = '{8'hA5, 8'h02, 8'h11, 8'h02};
    logic        vw [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int n;
        reset_n = 1'b0;
        cpu_ab  = 16'h8000;
        cpu_do  = 8'h00;
        cpu_we  = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            mem[16'h0300 + i] = 8'(i + 17);
            mem[16'hFF00 + i] = 8'(255 - i) ^ 8'h33;
        end
        mem[0] = 8'hC3;
        #12;
        check("rst_rdy", cpu_rdy, 1'b1);
        check("rst_busy", dma_busy, 1'b0);
        check("rst_pass", {bus_ab, bus_do, bus_we}, {16'h8000, 8'h00, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Non-trigger accesses pass straight through and never stall.
        for (int k = 0; k < 4; k++) begin
            cpu_ab = va[k];
            cpu_do = vd[k];
            cpu_we = vw[k];
            #1 check("pass", {bus_ab, bus_do, bus_we}, {va[k], vd[k], vw[k]});
            @(negedge clk);
            check("pass_rdy", {cpu_rdy, dma_busy}, 2'b10);
        end
        cpu_ab = 16'h8000;
        cpu_we = 1'b0;
        @(negedge clk);

        // Page 02 with even then odd HALT parity.
        align_to(1'b0);
        dma_run(8'h02, 1'b0, 1'b0, 8'h00);
        check("first_5A", wq[0], 8'h5A);
        check("last_A5", wq[255], 8'hA5);
        @(negedge clk);
        align_to(1'b1);
        dma_run(8'h02, 1'b0, 1'b0, 8'h00);

        // Page FF stays inside FF00..FFFF.
        @(negedge clk);
        dma_run(8'hFF, 1'b0, 1'b0, 8'h00);

        // Reset during write #100, then a fresh page 03 transfer.
        @(negedge clk);
        cpu_ab = 16'h4014;
        cpu_we = 1'b1;
        cpu_do = 8'h02;
        rq.delete();
        wq.delete();
        @(posedge clk);
        @(negedge clk);
        cpu_ab = 16'h8000;
        cpu_we = 1'b0;
        n = 0;
        while (!(wq.size() == 99 && bus_we && dma_busy) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("reach_wr100", wq.size(), 99);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rdy", cpu_rdy, 1'b1);
        check("mid_rst_busy", dma_busy, 1'b0);
        check("mid_rst_pass", {bus_ab, bus_we}, {16'h8000, 1'b0});
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("no_resume", {cpu_rdy, 8'(wq.size())}, {1'b1, 8'd99});
        dma_run(8'h03, 1'b0, 1'b0, 8'h00);

        // Back-to-back: writes to 0x4014 during the stall are ignored, then retrigger at once.
        @(negedge clk);
        dma_run(8'h02, 1'b0, 1'b1, 8'h03);
        check("b2b_idle", cpu_rdy, 1'b1);
        dma_run(8'h03, 1'b1, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
